// File: rtl/instr_encoder_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_loader_if
// Brief    : Field stream, memory write port and status bundle of the
//            RV32I instruction encoder/loader.
// Revision : 1.0
// ============================================================================
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [2:0]        in_funct3;
    logic              in_sub;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   count;

    modport master (
        output start, in_valid, in_kind, in_funct3, in_sub, in_rd, in_rs1,
               in_rs2, in_imm, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err,
               err_code, count
    );

    modport slave (
        input  start, in_valid, in_kind, in_funct3, in_sub, in_rd, in_rs1,
               in_rs2, in_imm, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err,
               err_code, count
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_loader
// Brief    : Packs RV32I instruction fields into machine words and writes them
//            sequentially into instruction memory. Define ENCODER_CHECK_EN to
//            enable funct3/immediate legality checking.
// Revision : 1.0
// ============================================================================
module instr_encoder_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input wire clk,
    input wire rst,
    instr_encoder_loader_if.slave bus
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_WRITE = 3'd2;
    localparam logic [2:0] c_ST_DONE  = 3'd3;
    localparam logic [2:0] c_ST_ERR   = 3'd4;

    localparam logic [2:0] c_K_LW   = 3'd0;
    localparam logic [2:0] c_K_SW   = 3'd1;
    localparam logic [2:0] c_K_R    = 3'd2;
    localparam logic [2:0] c_K_IA   = 3'd3;
    localparam logic [2:0] c_K_BR   = 3'd4;
    localparam logic [2:0] c_K_JALR = 3'd5;
    localparam logic [2:0] c_K_JAL  = 3'd6;

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_REG   = 7'b0110011;
    localparam logic [6:0] c_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;

    localparam logic [ADDR_W-1:0] c_BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W+1)'(DEPTH);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [31:0]       r_word;
    logic              r_last;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic [1:0]        r_err_code;

    logic [31:0]       w_word;
    logic [1:0]        w_chk_code;
    logic [1:0]        w_fail_code;
    logic              w_accept;
    logic              w_restart;
    logic              w_in_ready;
    logic              w_mem_we;
    logic              w_busy;
    logic              w_done;
    logic              w_err;

    // ------------------------------------------------------------------
    // Field packing; immediates are truncated to the bits each format holds
    // ------------------------------------------------------------------
    always_comb begin
        w_word = 32'd0;
        case (bus.in_kind)
            c_K_LW:   w_word = {bus.in_imm[11:0], bus.in_rs1, 3'b010,
                                bus.in_rd, c_OP_LOAD};
            c_K_SW:   w_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1,
                                3'b010, bus.in_imm[4:0], c_OP_STORE};
            c_K_R:    w_word = {1'b0, bus.in_sub, 5'b00000, bus.in_rs2,
                                bus.in_rs1, bus.in_funct3, bus.in_rd, c_OP_REG};
            c_K_IA:   w_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                                bus.in_rd, c_OP_IMM};
            c_K_BR:   w_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2,
                                bus.in_rs1, bus.in_funct3, bus.in_imm[4:1],
                                bus.in_imm[11], c_OP_BR};
            c_K_JALR: w_word = {bus.in_imm[11:0], bus.in_rs1, 3'b000,
                                bus.in_rd, c_OP_JALR};
            c_K_JAL:  w_word = {bus.in_imm[20], bus.in_imm[10:1],
                                bus.in_imm[11], bus.in_imm[19:12],
                                bus.in_rd, c_OP_JAL};
            default:  w_word = {bus.in_imm[31:12], bus.in_rd, c_OP_LUI};
        endcase
    end

`ifdef ENCODER_CHECK_EN
    localparam logic signed [31:0] c_I_MIN = -32'sd2048;
    localparam logic signed [31:0] c_I_MAX = 32'sd2047;
    localparam logic signed [31:0] c_B_MIN = -32'sd4096;
    localparam logic signed [31:0] c_B_MAX = 32'sd4094;
    localparam logic signed [31:0] c_J_MIN = -32'sd1048576;
    localparam logic signed [31:0] c_J_MAX = 32'sd1048574;

    logic signed [31:0] w_imm_s;
    logic               w_f3_legal;
    logic               w_imm_ok;

    assign w_imm_s = $signed(bus.in_imm);

    always_comb begin
        w_f3_legal = 1'b1;
        w_imm_ok   = 1'b1;
        case (bus.in_kind)
            c_K_LW, c_K_SW, c_K_JALR: begin
                w_imm_ok = (w_imm_s >= c_I_MIN) && (w_imm_s <= c_I_MAX);
            end
            c_K_R: begin
                w_f3_legal = (bus.in_funct3 == 3'b000) ||
                             (!bus.in_sub && ((bus.in_funct3 == 3'b111) ||
                                              (bus.in_funct3 == 3'b110) ||
                                              (bus.in_funct3 == 3'b010)));
            end
            c_K_IA: begin
                w_f3_legal = !bus.in_sub && ((bus.in_funct3 == 3'b000) ||
                                             (bus.in_funct3 == 3'b100) ||
                                             (bus.in_funct3 == 3'b110) ||
                                             (bus.in_funct3 == 3'b010));
                w_imm_ok   = (w_imm_s >= c_I_MIN) && (w_imm_s <= c_I_MAX);
            end
            c_K_BR: begin
                w_f3_legal = (bus.in_funct3 == 3'b000) || (bus.in_funct3 == 3'b001) ||
                             (bus.in_funct3 == 3'b100) || (bus.in_funct3 == 3'b101);
                w_imm_ok   = (w_imm_s >= c_B_MIN) && (w_imm_s <= c_B_MAX) &&
                             !bus.in_imm[0];
            end
            c_K_JAL: begin
                w_imm_ok = (w_imm_s >= c_J_MIN) && (w_imm_s <= c_J_MAX) &&
                           !bus.in_imm[0];
            end
            default: begin
                w_imm_ok = (bus.in_imm[11:0] == 12'd0);
            end
        endcase
    end

    // Encoding legality outranks immediate range
    assign w_chk_code = !w_f3_legal ? 2'd1 : (!w_imm_ok ? 2'd2 : 2'd0);
`else
    assign w_chk_code = 2'd0;
`endif

    assign w_fail_code = (w_chk_code != 2'd0) ? w_chk_code :
                         ((r_count == c_DEPTH) ? 2'd3 : 2'd0);
    assign w_accept    = (r_state == c_ST_LOAD) && bus.in_valid;
    assign w_restart   = bus.start && ((r_state == c_ST_IDLE) ||
                                       (r_state == c_ST_DONE) ||
                                       (r_state == c_ST_ERR));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DONE, c_ST_ERR: begin
                if (bus.start) begin
                    w_state_nxt = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                if (bus.in_valid) begin
                    w_state_nxt = (w_fail_code != 2'd0) ? c_ST_ERR : c_ST_WRITE;
                end
            end
            c_ST_WRITE: begin
                w_state_nxt = r_last ? c_ST_DONE : c_ST_LOAD;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_in_ready = 1'b0;
        w_mem_we   = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            c_ST_LOAD: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
            end
            c_ST_WRITE: begin
                w_mem_we = 1'b1;
                w_busy   = 1'b1;
            end
            c_ST_DONE: w_done = 1'b1;
            c_ST_ERR:  w_err  = 1'b1;
            default: begin
                w_in_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: pending word, write address, word count, error code
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word     <= 32'd0;
            r_last     <= 1'b0;
            r_addr     <= c_BASE;
            r_count    <= '0;
            r_err_code <= 2'd0;
        end else if (w_restart) begin
            r_addr     <= c_BASE;
            r_count    <= '0;
            r_err_code <= 2'd0;
        end else if (w_accept) begin
            if (w_fail_code == 2'd0) begin
                r_word <= w_word;
                r_last <= bus.in_last;
            end else begin
                r_err_code <= w_fail_code;
            end
        end else if (r_state == c_ST_WRITE) begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_count <= r_count + (ADDR_W+1)'(1);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_word;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.err       = w_err;
    assign bus.err_code  = r_err_code;
    assign bus.count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder_loader
// Brief    : Self-checking bench: directed vector table, hand sequences and
//            random programs against a field-level reference encoder.
// Revision : 1.0
// ============================================================================
module tb_instr_encoder_loader;

`ifdef ENCODER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [2:0]  kind;
        logic [2:0]  f3;
        logic        sub;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } instr_t;

    typedef struct {
        instr_t      ins;
        logic [31:0] word;
        int          chk_code;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 0, valid = 0, sub = 0, last = 0;
    logic [2:0]  kind = 0, f3 = 0;
    logic [4:0]  rd = 0, rs1 = 0, rs2 = 0;
    logic [31:0] imm = 0;
    bit          sel = 0;

    int checks   = 0;
    int failures = 0;

    instr_encoder_loader_if #(.ADDR_W(10)) b1();
    instr_encoder_loader_if #(.ADDR_W(10)) b2();

    assign b1.start = start;  assign b2.start = start;
    assign b1.in_valid = valid;  assign b2.in_valid = valid;
    assign b1.in_kind = kind;  assign b2.in_kind = kind;
    assign b1.in_funct3 = f3;  assign b2.in_funct3 = f3;
    assign b1.in_sub = sub;  assign b2.in_sub = sub;
    assign b1.in_rd = rd;  assign b2.in_rd = rd;
    assign b1.in_rs1 = rs1;  assign b2.in_rs1 = rs1;
    assign b1.in_rs2 = rs2;  assign b2.in_rs2 = rs2;
    assign b1.in_imm = imm;  assign b2.in_imm = imm;
    assign b1.in_last = last;  assign b2.in_last = last;

    instr_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0), .DEPTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    instr_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0), .DEPTH(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2.slave)
    );

    logic        w_ready, w_we, w_busy, w_done, w_err;
    logic [1:0]  w_code;
    logic [9:0]  w_addr;
    logic [31:0] w_wdata;
    logic [10:0] w_count;

    always_comb begin
        w_ready = sel ? b2.in_ready  : b1.in_ready;
        w_we    = sel ? b2.mem_we    : b1.mem_we;
        w_busy  = sel ? b2.busy      : b1.busy;
        w_done  = sel ? b2.done      : b1.done;
        w_err   = sel ? b2.err       : b1.err;
        w_code  = sel ? b2.err_code  : b1.err_code;
        w_addr  = sel ? b2.mem_addr  : b1.mem_addr;
        w_wdata = sel ? b2.mem_wdata : b1.mem_wdata;
        w_count = sel ? b2.count     : b1.count;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic instr_t mk(input int k, input int fn3, input int sb, input int d,
                                  input int s1, input int s2, input int im);
        instr_t t;
        t.kind = 3'(k);  t.f3 = 3'(fn3);  t.sub = sb[0];
        t.rd = 5'(d);  t.rs1 = 5'(s1);  t.rs2 = 5'(s2);  t.imm = im;
        return t;
    endfunction

    // Reference encoder built from the instruction-set field layout
    function automatic void model(input instr_t t, output logic [31:0] w, output int code);
        int          s;
        logic [31:0] u, op, fn3, rdv, r1, r2;
        bit          legal, in_rng;
        s = $signed(t.imm);  u = t.imm;
        rdv = 32'(t.rd) << 7;  r1 = 32'(t.rs1) << 15;  r2 = 32'(t.rs2) << 20;
        fn3 = 32'(t.f3) << 12;
        legal = 1;  in_rng = 1;  w = 0;
        case (t.kind)
            3'd0, 3'd5: begin
                op  = (t.kind == 0) ? 32'h03 : 32'h67;
                fn3 = (t.kind == 0) ? (32'd2 << 12) : 32'd0;
                in_rng = (s >= -2048) && (s <= 2047);
                w = op + rdv + fn3 + r1 + ((u & 32'hFFF) << 20);
            end
            3'd1: begin
                in_rng = (s >= -2048) && (s <= 2047);
                w = 32'h23 + ((u & 31) << 7) + (32'd2 << 12) + r1 + r2 + (((u >> 5) & 127) << 25);
            end
            3'd2: begin
                legal = (t.f3 == 0) || (!t.sub && (t.f3 inside {3'd2, 3'd6, 3'd7}));
                w = 32'h33 + rdv + fn3 + r1 + r2 + (t.sub ? (32'd32 << 25) : 32'd0);
            end
            3'd3: begin
                legal  = !t.sub && (t.f3 inside {3'd0, 3'd2, 3'd4, 3'd6});
                in_rng = (s >= -2048) && (s <= 2047);
                w = 32'h13 + rdv + fn3 + r1 + ((u & 32'hFFF) << 20);
            end
            3'd4: begin
                legal  = t.f3 inside {3'd0, 3'd1, 3'd4, 3'd5};
                in_rng = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
                w = 32'h63 + (((u >> 11) & 1) << 7) + (((u >> 1) & 15) << 8) + fn3 + r1 + r2 +
                    (((u >> 5) & 63) << 25) + (((u >> 12) & 1) << 31);
            end
            3'd6: begin
                in_rng = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
                w = 32'h6F + rdv + (((u >> 12) & 255) << 12) + (((u >> 11) & 1) << 20) +
                    (((u >> 1) & 1023) << 21) + (((u >> 20) & 1) << 31);
            end
            default: begin
                in_rng = (u % 4096) == 0;
                w = 32'h37 + rdv + (u & 32'hFFFFF000);
            end
        endcase
        code = 0;
        if (CHK && !legal) code = 1;
        else if (CHK && !in_rng) code = 2;
    endfunction

    instr_t      pq[$];
    logic [31:0] wq[$];
    int          cq[$];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Loads the program in pq on the selected DUT and checks every cycle
    task automatic run_prog(input bit which, input bit rand_gap);
        int cnt = 0;
        bit errd = 0;
        sel = which;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("load_ready", 32'(w_ready), 1);
        chk("load_count", 32'(w_count), 0);
        chk("load_flags", {w_err, w_done, w_code}, 0);
        for (int i = 0; i < pq.size(); i++) begin
            if (rand_gap) begin
                repeat ($urandom_range(0, 2)) begin
                    start = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    start = 1'b0;
                    chk("gap_ready", 32'(w_ready), 1);
                end
            end
            kind = pq[i].kind;  f3 = pq[i].f3;  sub = pq[i].sub;
            rd = pq[i].rd;  rs1 = pq[i].rs1;  rs2 = pq[i].rs2;  imm = pq[i].imm;
            last = (i == pq.size() - 1);
            valid = 1'b1;
            @(negedge clk);
            valid = 1'b0;
            if (cq[i] != 0) begin
                chk("err_flag", 32'(w_err), 1);
                chk("err_code", 32'(w_code), 32'(cq[i]));
                chk("err_no_we", 32'(w_we), 0);
                chk("err_ready", 32'(w_ready), 0);
                @(negedge clk);
                chk("err_hold", {w_err, w_we, w_ready, w_busy}, 4'b1000);
                chk("err_count", 32'(w_count), 32'(cnt));
                errd = 1;
                break;
            end
            chk("write_we", 32'(w_we), 1);
            chk("write_addr", 32'(w_addr), 32'(cnt));
            chk("write_data", w_wdata, wq[i]);
            chk("write_ready", 32'(w_ready), 0);
            @(negedge clk);
            cnt++;
            chk("post_we", 32'(w_we), 0);
            chk("post_count", 32'(w_count), 32'(cnt));
            chk("post_addr", 32'(w_addr), 32'(cnt));
            if (last) chk("done", {w_done, w_busy, w_err}, 3'b100);
            else      chk("next_ready", 32'(w_ready), 1);
        end
        pq.delete();  wq.delete();  cq.delete();
        if (errd) do_reset();
    endtask

    vec_t tbl[13];

    initial begin
        #1;
        chk("rst_outputs", {b1.mem_we, b1.busy, b1.done, b1.err, b1.in_ready, b1.err_code},
            0);
        chk("rst_addr_count", {12'd0, b1.mem_addr, b1.count}, 0);
        @(negedge clk);
        rst = 1'b0;

        tbl[0]  = '{mk(3, 0, 0, 1, 0, 0, 5),              32'h00500093, 0};
        tbl[1]  = '{mk(2, 0, 1, 3, 1, 2, 0),              32'h402081B3, 0};
        tbl[2]  = '{mk(7, 0, 0, 5, 0, 0, 32'h12345000),   32'h123452B7, 0};
        tbl[3]  = '{mk(4, 0, 0, 0, 1, 2, -8),             32'hFE208CE3, 0};
        tbl[4]  = '{mk(0, 0, 0, 5, 2, 0, -4),             32'hFFC12283, 0};
        tbl[5]  = '{mk(1, 0, 0, 0, 7, 6, 8),              32'h0063A423, 0};
        tbl[6]  = '{mk(5, 0, 0, 1, 5, 0, 0),              32'h000280E7, 0};
        tbl[7]  = '{mk(3, 0, 0, 1, 0, 0, 2047),           32'h7FF00093, 0};
        tbl[8]  = '{mk(6, 0, 0, 1, 0, 0, -4),             32'hFFDFF0EF, 0};
        tbl[9]  = '{mk(6, 0, 0, 1, 0, 0, 3),              32'h002000EF, 2};
        tbl[10] = '{mk(2, 7, 1, 3, 1, 2, 0),              32'h4020F1B3, 1};
        tbl[11] = '{mk(3, 0, 0, 1, 0, 0, 2048),           32'h80000093, 2};
        tbl[12] = '{mk(7, 0, 0, 1, 0, 0, 32'h00001001),   32'h000010B7, 2};

        foreach (tbl[i]) begin
            pq.push_back(tbl[i].ins);
            wq.push_back(tbl[i].word);
            cq.push_back(CHK ? tbl[i].chk_code : 0);
            run_prog(1'b0, 1'b0);
        end

        // Two back-to-back words: sub then lui
        pq = '{tbl[1].ins, tbl[2].ins};
        wq = '{tbl[1].word, tbl[2].word};
        cq = '{0, 0};
        run_prog(1'b0, 1'b0);

        // Overflow on a two-word memory
        pq = '{tbl[0].ins, tbl[0].ins, tbl[0].ins};
        wq = '{32'h00500093, 32'h00500093, 32'h00500093};
        cq = '{0, 0, 3};
        run_prog(1'b1, 1'b0);

        // Asynchronous reset during the write cycle
        sel = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        kind = 3'd3; f3 = 3'd0; sub = 1'b0; rd = 5'd1; rs1 = 5'd0; imm = 32'd5;
        last = 1'b1; valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        chk("pre_rst_we", 32'(w_we), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(w_we), 0);
        chk("mid_rst_outs", {w_busy, w_done, w_err, w_ready, w_code}, 0);
        chk("mid_rst_state", {w_wdata[9:0], w_addr, w_count}, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("after_rst_idle", {w_busy, w_ready, w_done}, 0);
        pq = '{tbl[0].ins};
        wq = '{32'h00500093};
        cq = '{0};
        run_prog(1'b0, 1'b0);

        // Random programs against the reference encoder
        for (int p = 0; p < 40; p++) begin
            bit which;
            int n, depth, cnt;
            which = ($urandom_range(0, 3) == 0);
            depth = which ? 2 : 256;
            n = $urandom_range(1, 5);
            cnt = 0;
            for (int i = 0; i < n; i++) begin
                instr_t t;
                logic [31:0] w;
                int c, m;
                m = $urandom_range(0, 3);
                t.kind = 3'($urandom_range(0, 7));
                t.f3 = 3'($urandom_range(0, 7));
                t.sub = ($urandom_range(0, 3) == 0);
                t.rd = 5'($urandom);  t.rs1 = 5'($urandom);  t.rs2 = 5'($urandom);
                case (m)
                    0: t.imm = $urandom_range(0, 8191) - 4096;
                    1: t.imm = ($urandom_range(0, 4095) - 2048) * 2;
                    2: t.imm = $urandom;
                    default: t.imm = $urandom & 32'hFFFFF000;
                endcase
                model(t, w, c);
                if (c == 0 && cnt == depth) c = 3;
                pq.push_back(t);  wq.push_back(w);  cq.push_back(c);
                if (c != 0) break;
                cnt++;
            end
            run_prog(which, 1'b1);
            if (which) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
